exec_stage_md: RTL and testbench

//  Parametrised execute stage for the RV32IM pipeline. Keeps operand forwarding, ALU

---
 rtl/exec_stage_md_if.sv | 56 +++++
 rtl/exec_stage_md.sv | 264 ++++++++++++++++++++++++++
 tb/tb_exec_stage_md.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/exec_stage_md_if.sv
// ============================================================================
// Module   : exec_stage_md_if
// Brief    : Handshake and data bundle between ID/EX, the execute stage and
//            EX/MEM. The master side feeds the stage; the slave is the stage.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface exec_stage_md_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic            flush;
    logic            md_en;
    logic [2:0]      md_op;
    logic [4:0]      alu_ctrl;
    logic            jump;
    logic            branch;
    logic            sel_a_pc;
    logic            sel_b_imm;
    logic            tgt_rs1;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [1:0]      fwd_a;
    logic [1:0]      fwd_b;
    logic [XLEN-1:0] result_w;
    logic [XLEN-1:0] alu_result_m;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] write_data;
    logic [XLEN-1:0] pc_target;
    logic            redirect;
    logic            stall_o;

    modport master (
        output in_valid, flush, md_en, md_op, alu_ctrl, jump, branch,
               sel_a_pc, sel_b_imm, tgt_rs1, rd1, rd2, pc, imm,
               fwd_a, fwd_b, result_w, alu_result_m, out_ready,
        input  in_ready, out_valid, result, write_data, pc_target,
               redirect, stall_o
    );

    modport slave (
        input  in_valid, flush, md_en, md_op, alu_ctrl, jump, branch,
               sel_a_pc, sel_b_imm, tgt_rs1, rd1, rd2, pc, imm,
               fwd_a, fwd_b, result_w, alu_result_m, out_ready,
        output in_ready, out_valid, result, write_data, pc_target,
               redirect, stall_o
    );
endinterface

`default_nettype wire

// File: rtl/exec_stage_md.sv
// ============================================================================
// Module   : exec_stage_md
// Brief    : RV32IM execute stage: forwarding, ALU, branch/jump resolution and
//            a multi-cycle multiply / radix-2 restoring divide unit.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module exec_stage_md #(
    parameter int XLEN     = 32,
    parameter int MUL_LAT  = 2,
    parameter int DIV_ITER = 32
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    exec_stage_md_if.slave     bus
);
    localparam int SH_W    = $clog2(XLEN);
    localparam int CNT_MAX = (DIV_ITER > MUL_LAT) ? DIV_ITER : MUL_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_ITER - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_SLL  = 5'd2;
    localparam logic [4:0] ALU_SLT  = 5'd3;
    localparam logic [4:0] ALU_SLTU = 5'd4;
    localparam logic [4:0] ALU_XOR  = 5'd5;
    localparam logic [4:0] ALU_SRL  = 5'd6;
    localparam logic [4:0] ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_OR   = 5'd8;
    localparam logic [4:0] ALU_AND  = 5'd9;
    localparam logic [4:0] ALU_EQ   = 5'd10;
    localparam logic [4:0] ALU_NE   = 5'd11;
    localparam logic [4:0] ALU_LT   = 5'd12;
    localparam logic [4:0] ALU_GE   = 5'd13;
    localparam logic [4:0] ALU_LTU  = 5'd14;
    localparam logic [4:0] ALU_GEU  = 5'd15;
    localparam logic [4:0] ALU_PASSB = 5'd16;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    logic [XLEN-1:0] op_a_q, op_a_d;
    logic [XLEN-1:0] op_b_q, op_b_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic [XLEN-1:0] res_q, res_d;
    logic [XLEN-1:0] wd_q, wd_d;
    logic [XLEN-1:0] pct_q, pct_d;

    logic [XLEN-1:0] rs1, rs2, alu_a, alu_b, alu_out;
    logic [XLEN-1:0] tgt_sum, pc_tgt;
    logic [SH_W-1:0] shamt;

    // Operand forwarding; 2'b11 falls back to the register file.
    always_comb begin
        case (bus.fwd_a)
            2'b01:   rs1 = bus.result_w;
            2'b10:   rs1 = bus.alu_result_m;
            default: rs1 = bus.rd1;
        endcase
        case (bus.fwd_b)
            2'b01:   rs2 = bus.result_w;
            2'b10:   rs2 = bus.alu_result_m;
            default: rs2 = bus.rd2;
        endcase
    end

    assign alu_a = bus.sel_a_pc  ? bus.pc  : rs1;
    assign alu_b = bus.sel_b_imm ? bus.imm : rs2;
    assign shamt = alu_b[SH_W-1:0];

    always_comb begin
        alu_out = '0;
        case (bus.alu_ctrl)
            ALU_ADD:   alu_out = alu_a + alu_b;
            ALU_SUB:   alu_out = alu_a - alu_b;
            ALU_SLL:   alu_out = alu_a << shamt;
            ALU_SLT:   alu_out = {{(XLEN-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
            ALU_SLTU:  alu_out = {{(XLEN-1){1'b0}}, alu_a < alu_b};
            ALU_XOR:   alu_out = alu_a ^ alu_b;
            ALU_SRL:   alu_out = alu_a >> shamt;
            ALU_SRA:   alu_out = $unsigned($signed(alu_a) >>> shamt);
            ALU_OR:    alu_out = alu_a | alu_b;
            ALU_AND:   alu_out = alu_a & alu_b;
            ALU_EQ:    alu_out = {{(XLEN-1){1'b0}}, alu_a == alu_b};
            ALU_NE:    alu_out = {{(XLEN-1){1'b0}}, alu_a != alu_b};
            ALU_LT:    alu_out = {{(XLEN-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
            ALU_GE:    alu_out = {{(XLEN-1){1'b0}}, $signed(alu_a) >= $signed(alu_b)};
            ALU_LTU:   alu_out = {{(XLEN-1){1'b0}}, alu_a < alu_b};
            ALU_GEU:   alu_out = {{(XLEN-1){1'b0}}, alu_a >= alu_b};
            ALU_PASSB: alu_out = alu_b;
            default:   alu_out = '0;
        endcase
    end

    // JALR targets clear bit 0; branch/JAL targets are already halfword aligned.
    assign tgt_sum = (bus.tgt_rs1 ? rs1 : bus.pc) + bus.imm;
    assign pc_tgt  = {tgt_sum[XLEN-1:1], tgt_sum[0] & ~bus.tgt_rs1};

    // Multiplier: sign-extend to 2*XLEN so one unsigned multiply covers all four ops.
    logic            mul_a_signed, mul_b_signed;
    logic [2*XLEN-1:0] mul_a_ext, mul_b_ext, prod;
    logic [XLEN-1:0] mul_res;

    assign mul_a_signed = (op_q == OP_MULH) || (op_q == OP_MULHSU);
    assign mul_b_signed = (op_q == OP_MULH);
    assign mul_a_ext = {{XLEN{mul_a_signed & op_a_q[XLEN-1]}}, op_a_q};
    assign mul_b_ext = {{XLEN{mul_b_signed & op_b_q[XLEN-1]}}, op_b_q};
    assign prod      = mul_a_ext * mul_b_ext;
    assign mul_res   = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    // Divider setup from live operands; md_op[0]=0 means signed, md_op[1]=1 means remainder.
    logic            in_signed, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag, special_res;

    assign in_signed = ~bus.md_op[0];
    assign a_neg     = in_signed & rs1[XLEN-1];
    assign b_neg     = in_signed & rs2[XLEN-1];
    assign a_mag     = a_neg ? -rs1 : rs1;
    assign b_mag     = b_neg ? -rs2 : rs2;
    assign div_zero  = (rs2 == '0);
    assign div_ovf   = in_signed & (rs1 == INT_MIN) & (rs2 == '1);
    assign special_res = div_zero ? (bus.md_op[1] ? rs1 : '1)
                                  : (bus.md_op[1] ? '0  : rs1);

    // One restoring step: op_a_q shifts dividend bits out and quotient bits in.
    logic [XLEN:0]   rem_sh, rem_sub;
    logic            q_bit;
    logic [XLEN-1:0] rem_nxt, quo_nxt, div_res;

    assign rem_sh  = {rem_q, op_a_q[XLEN-1]};
    assign rem_sub = rem_sh - {1'b0, op_b_q};
    assign q_bit   = ~rem_sub[XLEN];
    assign rem_nxt = q_bit ? rem_sub[XLEN-1:0] : rem_sh[XLEN-1:0];
    assign quo_nxt = {op_a_q[XLEN-2:0], q_bit};
    assign div_res = op_q[1] ? (neg_rem_q ? -rem_nxt : rem_nxt)
                             : (neg_quo_q ? -quo_nxt : quo_nxt);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        rem_d     = rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        res_d     = res_q;
        wd_d      = wd_q;
        pct_d     = pct_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid && bus.md_en) begin
                    op_d  = bus.md_op;
                    wd_d  = rs2;
                    pct_d = pc_tgt;
                    cnt_d = '0;
                    rem_d = '0;
                    if (!bus.md_op[2]) begin
                        state_d = S_MUL;
                        op_a_d  = rs1;
                        op_b_d  = rs2;
                    end else if (div_zero || div_ovf) begin
                        state_d = S_DONE;
                        res_d   = special_res;
                    end else begin
                        state_d   = S_DIV;
                        op_a_d    = a_mag;
                        op_b_d    = b_mag;
                        neg_quo_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                    end
                end
            end
            S_MUL: begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == MUL_LAST) begin
                    res_d   = mul_res;
                    state_d = S_DONE;
                end
            end
            S_DIV: begin
                op_a_d = quo_nxt;
                rem_d  = rem_nxt;
                cnt_d  = cnt_q + CNT_ONE;
                if (cnt_q == DIV_LAST) begin
                    res_d   = div_res;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (bus.flush) state_d = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            rem_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            res_q     <= '0;
            wd_q      <= '0;
            pct_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            rem_q     <= rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            res_q     <= res_d;
            wd_q      <= wd_d;
            pct_q     <= pct_d;
        end
    end

    // rst_n gates the combinational paths so nothing asserts while reset is held.
    logic is_idle, is_busy, is_done, live;

    assign is_idle = (state_q == S_IDLE);
    assign is_done = (state_q == S_DONE);
    assign is_busy = (state_q == S_MUL) || (state_q == S_DIV);
    assign live    = rst_n & ~bus.flush;

    assign bus.in_ready   = is_idle;
    assign bus.out_valid  = live & (is_idle ? (bus.in_valid & ~bus.md_en) : is_done);
    assign bus.redirect   = live & is_idle & bus.in_valid & ~bus.md_en
                            & (bus.jump | (bus.branch & alu_out[0]));
    assign bus.stall_o    = live & (is_busy | (is_done & ~bus.out_ready));
    assign bus.result     = (rst_n & is_idle) ? alu_out : res_q;
    assign bus.write_data = (rst_n & is_idle) ? rs2     : wd_q;
    assign bus.pc_target  = (rst_n & is_idle) ? pc_tgt  : pct_q;

endmodule

`default_nettype wire

// File: tb/tb_exec_stage_md.sv
// ============================================================================
// Module   : tb_exec_stage_md
// Brief    : Directed, table-driven bench for exec_stage_md.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_exec_stage_md;
    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_SLTU = 5'd4;
    localparam logic [4:0] ALU_XOR  = 5'd5;
    localparam logic [4:0] ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_EQ   = 5'd10;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    exec_stage_md_if #(.XLEN(32)) bus ();

    exec_stage_md #(.XLEN(32), .MUL_LAT(2), .DIV_ITER(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  fa, fb;
        logic [31:0] rd1, rd2, rw, rm, pc, imm;
        logic [4:0]  alu;
        logic        sa, sb, tr, jmp, br, iv;
        logic [31:0] e_res, e_wd, e_pct;
        logic        e_red, e_ov;
    } vec_t;

    vec_t vec [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.in_valid = 0; bus.flush = 0; bus.md_en = 0; bus.md_op = 0;
        bus.alu_ctrl = 0; bus.jump = 0; bus.branch = 0; bus.sel_a_pc = 0;
        bus.sel_b_imm = 0; bus.tgt_rs1 = 0; bus.rd1 = 0; bus.rd2 = 0;
        bus.pc = 0; bus.imm = 0; bus.fwd_a = 0; bus.fwd_b = 0;
        bus.result_w = 0; bus.alu_result_m = 0; bus.out_ready = 1;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_vec(input int i);
        clear_inputs();
        bus.fwd_a = vec[i].fa; bus.fwd_b = vec[i].fb;
        bus.rd1 = vec[i].rd1; bus.rd2 = vec[i].rd2;
        bus.result_w = vec[i].rw; bus.alu_result_m = vec[i].rm;
        bus.pc = vec[i].pc; bus.imm = vec[i].imm; bus.alu_ctrl = vec[i].alu;
        bus.sel_a_pc = vec[i].sa; bus.sel_b_imm = vec[i].sb; bus.tgt_rs1 = vec[i].tr;
        bus.jump = vec[i].jmp; bus.branch = vec[i].br; bus.in_valid = vec[i].iv;
        #2;
        chk($sformatf("v%0d result", i), bus.result, vec[i].e_res);
        chk($sformatf("v%0d write_data", i), bus.write_data, vec[i].e_wd);
        chk($sformatf("v%0d pc_target", i), bus.pc_target, vec[i].e_pct);
        chk($sformatf("v%0d redirect", i), {31'd0, bus.redirect}, {31'd0, vec[i].e_red});
        chk($sformatf("v%0d out_valid", i), {31'd0, bus.out_valid}, {31'd0, vec[i].e_ov});
        chk($sformatf("v%0d stall_o", i), {31'd0, bus.stall_o}, 32'd0);
        chk($sformatf("v%0d in_ready", i), {31'd0, bus.in_ready}, 32'd1);
        next_cyc();
    endtask

    // Issues one M op with out_ready held high and measures latency to out_valid.
    task automatic run_md(input string nm, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat, stalls, rdy_bad;
        bit seen;
        clear_inputs();
        bus.in_valid = 1; bus.md_en = 1; bus.md_op = op; bus.rd1 = a; bus.rd2 = b;
        #2;
        chk({nm, " accept_ready"}, {31'd0, bus.in_ready}, 32'd1);
        chk({nm, " no_early_valid"}, {31'd0, bus.out_valid}, 32'd0);
        next_cyc();
        bus.in_valid = 0; bus.md_en = 0;
        lat = 0; stalls = 0; rdy_bad = 0; seen = 0;
        for (int k = 1; k <= 100 && !seen; k++) begin
            #2;
            if (bus.out_valid) begin
                seen = 1;
                lat = k;
                chk({nm, " result"}, bus.result, exp);
            end else begin
                if (bus.stall_o) stalls++;
                if (bus.in_ready) rdy_bad++;
            end
            next_cyc();
        end
        chk({nm, " latency"}, lat, exp_lat);
        chk({nm, " stall_cycles"}, stalls, exp_lat - 1);
        chk({nm, " in_ready_busy"}, rdy_bad, 0);
    endtask

    initial begin
        int hold_bad;
        int cnt;
        checks = 0;
        errors = 0;

        //              fa fb rd1           rd2           rw     rm        pc       imm   alu       sa sb tr j  b  iv  e_res         e_wd          e_pct         red ov
        vec[0] = '{2'd2, 2'd0, 32'd9,        32'h11,       32'd0,  32'd5,    32'h100, 32'd3, ALU_ADD,  0, 1, 0, 0, 0, 1, 32'd8,        32'h11,       32'h103,      0, 1};
        vec[1] = '{2'd0, 2'd0, 32'h1003,     32'd0,        32'd0,  32'd0,    32'h200, 32'd4, ALU_ADD,  1, 1, 1, 1, 0, 1, 32'h204,      32'd0,        32'h1006,     1, 1};
        vec[2] = '{2'd0, 2'd0, 32'd5,        32'd6,        32'd0,  32'd0,    32'h300, 32'h10, ALU_EQ,  0, 0, 0, 0, 1, 1, 32'd0,        32'd6,        32'h310,      0, 1};
        vec[3] = '{2'd0, 2'd0, 32'd7,        32'd7,        32'd0,  32'd0,    32'h300, 32'h10, ALU_EQ,  0, 0, 0, 0, 1, 1, 32'd1,        32'd7,        32'h310,      1, 1};
        vec[4] = '{2'd3, 2'd1, 32'd3,        32'h55,       32'd10, 32'd0,    32'h400, 32'd0, ALU_SUB,  0, 0, 0, 0, 0, 1, 32'hFFFFFFF9, 32'd10,       32'h400,      0, 1};
        vec[5] = '{2'd0, 2'd0, 32'h80000000, 32'h22,       32'd0,  32'd0,    32'h500, 32'd4, ALU_SRA,  0, 1, 0, 0, 0, 1, 32'hF8000000, 32'h22,       32'h504,      0, 1};
        vec[6] = '{2'd0, 2'd0, 32'd1,        32'hFFFFFFFF, 32'd0,  32'd0,    32'h600, 32'd0, ALU_SLTU, 0, 0, 0, 0, 0, 1, 32'd1,        32'hFFFFFFFF, 32'h600,      0, 1};
        vec[7] = '{2'd0, 2'd0, 32'd0,        32'd0,        32'd0,  32'd0,    32'h700, 32'd8, ALU_ADD,  0, 0, 0, 1, 0, 0, 32'd0,        32'd0,        32'h708,      0, 0};
        vec[8] = '{2'd2, 2'd2, 32'd0,        32'd0,        32'd0,  32'hF0F0, 32'h800, 32'd0, ALU_XOR,  0, 0, 0, 0, 0, 1, 32'd0,        32'hF0F0,     32'h800,      0, 1};

        // Reset state, with live inputs that would otherwise raise out_valid/redirect.
        clear_inputs();
        rst_n = 0;
        bus.in_valid = 1; bus.jump = 1; bus.rd1 = 32'h1234; bus.imm = 32'h10;
        @(negedge clk);
        #2;
        chk("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("reset redirect", {31'd0, bus.redirect}, 32'd0);
        chk("reset stall_o", {31'd0, bus.stall_o}, 32'd0);
        chk("reset in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("reset result", bus.result, 32'd0);
        chk("reset pc_target", bus.pc_target, 32'd0);
        clear_inputs();
        next_cyc();
        rst_n = 1;
        next_cyc();

        for (int i = 0; i < 9; i++) apply_vec(i);

        run_md("MUL",      3'd0, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFEB, 3);
        run_md("MULH",     3'd1, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 3);
        run_md("MULHSU",   3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 3);
        run_md("MULHU",    3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 3);
        run_md("DIV",      3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
        run_md("REM",      3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
        run_md("DIVU",     3'd5, 32'd100,      32'd7,        32'd14,       33);
        run_md("REMU",     3'd7, 32'd100,      32'd7,        32'd2,        33);
        run_md("DIV_neg_b",3'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33);
        run_md("DIVU_z",   3'd5, 32'h1234,     32'd0,        32'hFFFFFFFF, 1);
        run_md("REM_z",    3'd6, 32'h1234,     32'd0,        32'h1234,     1);
        run_md("DIV_ovf",  3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run_md("REM_ovf",  3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

        // DONE holds its result while out_ready is low; stall drops with the handshake.
        clear_inputs();
        bus.out_ready = 0;
        bus.in_valid = 1; bus.md_en = 1; bus.md_op = 3'd0; bus.rd1 = 32'd6; bus.rd2 = 32'd7;
        next_cyc();
        bus.in_valid = 0; bus.md_en = 0;
        next_cyc();
        next_cyc();
        hold_bad = 0;
        for (int k = 0; k < 3; k++) begin
            #2;
            if (!bus.out_valid || bus.result !== 32'd42 || !bus.stall_o || bus.in_ready) hold_bad++;
            next_cyc();
        end
        chk("done_hold", hold_bad, 0);
        bus.out_ready = 1;
        #2;
        chk("done_hs out_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("done_hs stall_o", {31'd0, bus.stall_o}, 32'd0);
        next_cyc();
        #2;
        chk("after_hs in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("after_hs out_valid", {31'd0, bus.out_valid}, 32'd0);
        next_cyc();

        // Flush at divide cycle 10.
        clear_inputs();
        bus.in_valid = 1; bus.md_en = 1; bus.md_op = 3'd4; bus.rd1 = 32'd1000; bus.rd2 = 32'd3;
        next_cyc();
        bus.in_valid = 0; bus.md_en = 0;
        for (int k = 1; k < 10; k++) next_cyc();
        bus.flush = 1;
        #2;
        chk("flush out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("flush redirect", {31'd0, bus.redirect}, 32'd0);
        next_cyc();
        bus.flush = 0;
        #2;
        chk("flush idle in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("flush idle stall_o", {31'd0, bus.stall_o}, 32'd0);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            next_cyc();
            #2;
            if (bus.out_valid) cnt++;
        end
        chk("flush no_valid", cnt, 0);
        next_cyc();
        apply_vec(0);

        // Flush beats a simultaneous accept.
        clear_inputs();
        bus.in_valid = 1; bus.md_en = 1; bus.md_op = 3'd0; bus.rd1 = 32'd2; bus.rd2 = 32'd2;
        bus.flush = 1;
        next_cyc();
        clear_inputs();
        #2;
        chk("flush_accept in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("flush_accept stall_o", {31'd0, bus.stall_o}, 32'd0);
        next_cyc();

        // Reset asserted mid-multiply.
        clear_inputs();
        bus.in_valid = 1; bus.md_en = 1; bus.md_op = 3'd0; bus.rd1 = 32'd5; bus.rd2 = 32'd9;
        next_cyc();
        bus.md_en = 0; bus.jump = 1; bus.rd1 = 32'h40;
        #1;
        chk("mid_mul stall_o", {31'd0, bus.stall_o}, 32'd1);
        rst_n = 0;
        #1;
        chk("rst_mid out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_mid redirect", {31'd0, bus.redirect}, 32'd0);
        chk("rst_mid stall_o", {31'd0, bus.stall_o}, 32'd0);
        chk("rst_mid in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_mid result", bus.result, 32'd0);
        chk("rst_mid write_data", bus.write_data, 32'd0);
        next_cyc();
        #2;
        chk("rst_hold out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_hold result", bus.result, 32'd0);
        clear_inputs();
        rst_n = 1;
        next_cyc();
        apply_vec(3);
        run_md("MUL_after_rst", 3'd0, 32'd5, 32'd9, 32'd45, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end
endmodule

`default_nettype wire
